// File: rtl/proc_control_unit_pkg.sv
// Shared encodings for the processor control unit: FSM states, opcodes,
// ALU operation selects and the illegal-opcode decode.
package proc_control_unit_pkg;

    typedef enum logic [2:0] {
        ST_IDLE   = 3'd0,
        ST_FETCH  = 3'd1,
        ST_DECODE = 3'd2,
        ST_EXEC   = 3'd3,
        ST_MEM    = 3'd4,
        ST_HALT   = 3'd5,
        ST_FAULT  = 3'd6
    } state_t;

    localparam logic [3:0] OP_NOP = 4'd0;
    localparam logic [3:0] OP_ADD = 4'd1;
    localparam logic [3:0] OP_SUB = 4'd2;
    localparam logic [3:0] OP_AND = 4'd3;
    localparam logic [3:0] OP_OR  = 4'd4;
    localparam logic [3:0] OP_LD  = 4'd5;
    localparam logic [3:0] OP_ST  = 4'd6;
    localparam logic [3:0] OP_BEQ = 4'd7;
    localparam logic [3:0] OP_JMP = 4'd8;
    localparam logic [3:0] OP_HLT = 4'd15;

    localparam logic [3:0] OP_ILL_LO = 4'd9;
    localparam logic [3:0] OP_ILL_HI = 4'd14;

    localparam logic [2:0] ALU_ADD = 3'd0;
    localparam logic [2:0] ALU_SUB = 3'd1;
    localparam logic [2:0] ALU_AND = 3'd2;
    localparam logic [2:0] ALU_OR  = 3'd3;

    function automatic logic is_illegal(input logic [3:0] op);
        return (op >= OP_ILL_LO) && (op <= OP_ILL_HI);
    endfunction

endpackage

// File: rtl/proc_control_unit_timeout.sv
// Memory-handshake watchdog: 8-bit clear/enable counter, expired on the
// cycle in which the count of ack-less cycles reaches LIMIT.
module proc_control_unit_timeout #(
    parameter int LIMIT = 15
) (
    input  logic clk_in,
    input  logic rst_in,
    input  logic clr,
    input  logic en,
    output logic expired
);

    logic [7:0] count_r;

    // Wait-cycle counter; clear has priority over increment.
    always_ff @(posedge clk_in or negedge rst_in) begin
        if (!rst_in) begin
            count_r <= 8'd0;
        end else if (clr) begin
            count_r <= 8'd0;
        end else if (en) begin
            count_r <= count_r + 8'd1;
        end else begin
            count_r <= count_r;
        end
    end

    // The current ack-less cycle is the LIMIT-th one.
    assign expired = (count_r == 8'(LIMIT - 1));

endmodule

// File: rtl/proc_control_unit.sv
// Multi-cycle control FSM: fetch/decode/execute/memory sequencing, datapath
// strobes, memory handshake timeout, debug halt/resume and fault capture.
module proc_control_unit
    import proc_control_unit_pkg::*;
#(
    parameter int OPCODE_W    = 4,
    parameter int ALU_OP_W    = 3,
    parameter int MEM_TIMEOUT = 15
) (
    input  logic                clk_in,
    input  logic                rst_in,
    input  logic [OPCODE_W-1:0] opcode_in,
    input  logic                zero_in,
    input  logic                mem_ack_in,
    input  logic                halt_req_in,
    input  logic                resume_in,
    output logic                pc_inc_out,
    output logic                pc_load_out,
    output logic                ir_load_out,
    output logic                mem_req_out,
    output logic                mem_we_out,
    output logic                addr_sel_out,
    output logic [ALU_OP_W-1:0] alu_op_out,
    output logic                rf_we_out,
    output logic                wb_sel_out,
    output logic                halted_out,
    output logic                fault_out,
    output logic [2:0]          state_out
);

    state_t     state_r;
    state_t     state_next_s;
    state_t     boundary_s;
    logic [3:0] op_s;
    logic [2:0] alu_op_s;
    logic       expired_s;
    logic       tmo_clr_s;
    logic       tmo_en_s;

    assign op_s = 4'(opcode_in);
    // Instruction boundary: a pending halt request diverts the next fetch.
    assign boundary_s = halt_req_in ? ST_HALT : ST_FETCH;

    assign tmo_clr_s = (state_next_s != state_r);
    assign tmo_en_s  = ((state_r == ST_FETCH) || (state_r == ST_MEM)) && !mem_ack_in;

    proc_control_unit_timeout #(
        .LIMIT (MEM_TIMEOUT)
    ) u_timeout (
        .clk_in  (clk_in),
        .rst_in  (rst_in),
        .clr     (tmo_clr_s),
        .en      (tmo_en_s),
        .expired (expired_s)
    );

    // State register.
    always_ff @(posedge clk_in or negedge rst_in) begin
        if (!rst_in) begin
            state_r <= ST_IDLE;
        end else begin
            state_r <= state_next_s;
        end
    end

    // Next-state logic; an ack in the same cycle beats the timeout.
    always_comb begin
        state_next_s = state_r;
        case (state_r)
            ST_IDLE:   state_next_s = boundary_s;
            ST_FETCH: begin
                if (mem_ack_in)     state_next_s = ST_DECODE;
                else if (expired_s) state_next_s = ST_FAULT;
                else                state_next_s = ST_FETCH;
            end
            ST_DECODE: state_next_s = is_illegal(op_s) ? ST_FAULT : ST_EXEC;
            ST_EXEC: begin
                case (op_s)
                    OP_LD, OP_ST: state_next_s = ST_MEM;
                    OP_HLT:       state_next_s = ST_HALT;
                    default:      state_next_s = boundary_s;
                endcase
            end
            ST_MEM: begin
                if (mem_ack_in)     state_next_s = boundary_s;
                else if (expired_s) state_next_s = ST_FAULT;
                else                state_next_s = ST_MEM;
            end
            ST_HALT:   state_next_s = resume_in ? ST_FETCH : ST_HALT;
            ST_FAULT:  state_next_s = ST_FAULT;
            default:   state_next_s = ST_FAULT;
        endcase
    end

    // Strobe decode from state, opcode and same-cycle handshake flags.
    always_comb begin
        pc_inc_out   = 1'b0;
        pc_load_out  = 1'b0;
        ir_load_out  = 1'b0;
        mem_req_out  = 1'b0;
        mem_we_out   = 1'b0;
        addr_sel_out = 1'b0;
        alu_op_s     = ALU_ADD;
        rf_we_out    = 1'b0;
        wb_sel_out   = 1'b0;
        halted_out   = 1'b0;
        fault_out    = 1'b0;
        case (state_r)
            ST_FETCH: begin
                mem_req_out = 1'b1;
                ir_load_out = mem_ack_in;
                pc_inc_out  = mem_ack_in;
            end
            ST_EXEC: begin
                case (op_s)
                    OP_ADD: begin alu_op_s = ALU_ADD; rf_we_out = 1'b1; end
                    OP_SUB: begin alu_op_s = ALU_SUB; rf_we_out = 1'b1; end
                    OP_AND: begin alu_op_s = ALU_AND; rf_we_out = 1'b1; end
                    OP_OR:  begin alu_op_s = ALU_OR;  rf_we_out = 1'b1; end
                    OP_BEQ: begin alu_op_s = ALU_SUB; pc_load_out = zero_in; end
                    OP_JMP: pc_load_out = 1'b1;
                    OP_NOP: alu_op_s = ALU_ADD;
                    default: alu_op_s = ALU_ADD;
                endcase
            end
            ST_MEM: begin
                mem_req_out  = 1'b1;
                addr_sel_out = 1'b1;
                mem_we_out   = (op_s == OP_ST);
                rf_we_out    = mem_ack_in && (op_s == OP_LD);
                wb_sel_out   = mem_ack_in && (op_s == OP_LD);
            end
            ST_HALT:  halted_out = 1'b1;
            ST_FAULT: fault_out  = 1'b1;
            default:  halted_out = 1'b0;
        endcase
    end

    assign alu_op_out = ALU_OP_W'(alu_op_s);
    assign state_out  = state_r;

endmodule

// File: tb/tb_proc_control_unit.sv
// Cycle-level scoreboard bench for proc_control_unit: each step drives the
// inputs, queues the expected output vector and compares it mid-cycle.
module tb_proc_control_unit;

    logic       clk;
    logic       rst_n;
    logic [3:0] opcode;
    logic       zero, mem_ack, halt_req, resume;
    logic       pc_inc, pc_load, ir_load, mem_req, mem_we, addr_sel;
    logic [2:0] alu_op;
    logic       rf_we, wb_sel, halted, fault;
    logic [2:0] state;

    int n_tests = 0;
    int n_fail  = 0;
    logic [15:0] exp_q[$];
    logic [15:0] obs_s;

    // Expected-vector fields: {state[2:0], pc_inc, pc_load, ir_load, mem_req,
    // mem_we, addr_sel, alu_op[2:0], rf_we, wb_sel, halted, fault}
    localparam logic [15:0] S_IDLE  = 16'h0000, S_FETCH = 16'h2000, S_DECODE = 16'h4000;
    localparam logic [15:0] S_EXEC  = 16'h6000, S_MEM   = 16'h8000, S_HALT   = 16'hA000;
    localparam logic [15:0] S_FAULT = 16'hC000;
    localparam logic [15:0] PINC = 16'h1000, PLOAD = 16'h0800, IRL = 16'h0400, REQ = 16'h0200;
    localparam logic [15:0] WE   = 16'h0100, ASEL  = 16'h0080, RFWE = 16'h0008, WBS = 16'h0004;
    localparam logic [15:0] HLT  = 16'h0002, FLT   = 16'h0001;
    localparam logic [15:0] A_SUB = 16'h0010, A_AND = 16'h0020, A_OR = 16'h0030;
    // Input vector: {mem_ack, zero, halt_req, resume}
    localparam logic [3:0] NONE = 4'b0000, ACK = 4'b1000, ZRO = 4'b0100, HRQ = 4'b0010, RES = 4'b0001;

    proc_control_unit dut (
        .clk_in       (clk),
        .rst_in       (rst_n),
        .opcode_in    (opcode),
        .zero_in      (zero),
        .mem_ack_in   (mem_ack),
        .halt_req_in  (halt_req),
        .resume_in    (resume),
        .pc_inc_out   (pc_inc),
        .pc_load_out  (pc_load),
        .ir_load_out  (ir_load),
        .mem_req_out  (mem_req),
        .mem_we_out   (mem_we),
        .addr_sel_out (addr_sel),
        .alu_op_out   (alu_op),
        .rf_we_out    (rf_we),
        .wb_sel_out   (wb_sel),
        .halted_out   (halted),
        .fault_out    (fault),
        .state_out    (state)
    );

    assign obs_s = {state, pc_inc, pc_load, ir_load, mem_req, mem_we, addr_sel,
                    alu_op, rf_we, wb_sel, halted, fault};

    initial clk = 1'b0;
    always #5 clk = ~clk;

    task automatic check_eq(input string tag, input logic [15:0] obs, input logic [15:0] expv);
        n_tests++;
        if (obs !== expv) begin
            n_fail++;
            $display("FAIL %s: got %h expected %h (t=%0t)", tag, obs, expv, $time);
        end
    endtask

    // One clock cycle: drive at posedge+1, compare at negedge, return at posedge+1.
    task automatic step(input string tag, input logic [3:0] in_v, input logic [3:0] op,
                        input logic [15:0] expv);
        {mem_ack, zero, halt_req, resume} = in_v;
        opcode = op;
        exp_q.push_back(expv);
        @(negedge clk);
        check_eq(tag, obs_s, exp_q.pop_front());
        @(posedge clk);
        #1;
    endtask

    task automatic fetch(input logic [3:0] op, input int waits, input logic [3:0] in_v);
        for (int i = 0; i < waits; i++) step("fetch_wait", in_v, op, S_FETCH | REQ);
        step("fetch_ack", in_v | ACK, op, S_FETCH | REQ | IRL | PINC);
        step("decode", in_v, op, S_DECODE);
    endtask

    task automatic do_reset();
        rst_n = 1'b0;
        step("reset", NONE, 4'd0, S_IDLE);
        step("reset", NONE, 4'd0, S_IDLE);
        step("reset", NONE, 4'd0, S_IDLE);
        rst_n = 1'b1;
        step("idle", NONE, 4'd0, S_IDLE);
    endtask

    initial begin
        #200000;
        $display("FAIL watchdog: simulation time limit reached");
        $fatal(1, "watchdog");
    end

    initial begin
        rst_n = 1'b0;
        {mem_ack, zero, halt_req, resume} = NONE;
        opcode = 4'd0;
        @(posedge clk);
        #1;
        do_reset();

        // ALU ops; ADD gets its ack on the second FETCH cycle
        fetch(4'd1, 1, NONE);
        step("exec_add", NONE, 4'd1, S_EXEC | RFWE);
        fetch(4'd2, 0, NONE);
        step("exec_sub", NONE, 4'd2, S_EXEC | A_SUB | RFWE);
        fetch(4'd3, 0, NONE);
        step("exec_and", NONE, 4'd3, S_EXEC | A_AND | RFWE);
        fetch(4'd4, 0, NONE);
        step("exec_or", NONE, 4'd4, S_EXEC | A_OR | RFWE);

        // LD with three wait cycles, then ST
        fetch(4'd5, 0, NONE);
        step("exec_ld", NONE, 4'd5, S_EXEC);
        for (int i = 0; i < 3; i++) step("mem_ld_wait", NONE, 4'd5, S_MEM | REQ | ASEL);
        step("mem_ld_ack", ACK, 4'd5, S_MEM | REQ | ASEL | RFWE | WBS);
        fetch(4'd6, 0, NONE);
        step("exec_st", NONE, 4'd6, S_EXEC);
        step("mem_st_ack", ACK, 4'd6, S_MEM | REQ | ASEL | WE);

        // Branches, jump, and a NOP whose ack lands on the last allowed cycle
        fetch(4'd7, 0, NONE);
        step("beq_taken", ZRO, 4'd7, S_EXEC | A_SUB | PLOAD);
        fetch(4'd7, 0, NONE);
        step("beq_not", NONE, 4'd7, S_EXEC | A_SUB);
        fetch(4'd8, 0, NONE);
        step("jmp", NONE, 4'd8, S_EXEC | PLOAD);
        fetch(4'd0, 14, NONE);
        step("nop_ack_wins", NONE, 4'd0, S_EXEC);

        // Halt request during LD is held off until the memory ack
        fetch(4'd5, 0, HRQ);
        step("ld_h_exec", HRQ, 4'd5, S_EXEC);
        step("ld_h_wait", HRQ, 4'd5, S_MEM | REQ | ASEL);
        step("ld_h_ack", HRQ | ACK, 4'd5, S_MEM | REQ | ASEL | RFWE | WBS);
        step("halted", HRQ, 4'd0, S_HALT | HLT);
        step("resume_halt", HRQ | RES, 4'd0, S_HALT | HLT);
        fetch(4'd0, 0, HRQ);
        step("nop_h_exec", HRQ, 4'd0, S_EXEC);
        step("halt_again", HRQ, 4'd0, S_HALT | HLT);
        step("resume", RES, 4'd0, S_HALT | HLT);

        // HLT instruction
        fetch(4'd15, 0, NONE);
        step("exec_hlt", NONE, 4'd15, S_EXEC);
        step("hlt_halt", NONE, 4'd15, S_HALT | HLT);
        step("hlt_stay", NONE, 4'd15, S_HALT | HLT);
        step("hlt_resume", RES, 4'd15, S_HALT | HLT);

        // Async reset in FETCH drops mem_req in the same cycle
        step("pre_rst_fetch", NONE, 4'd0, S_FETCH | REQ);
        do_reset();

        // FETCH timeout and sticky FAULT
        for (int i = 0; i < 15; i++) step("fetch_tmo_wait", NONE, 4'd0, S_FETCH | REQ);
        step("fetch_tmo", NONE, 4'd0, S_FAULT | FLT);
        step("fault_sticky_ack", ACK, 4'd0, S_FAULT | FLT);
        step("fault_sticky_res", RES, 4'd0, S_FAULT | FLT);
        do_reset();

        // Illegal opcode faults after DECODE
        fetch(4'd10, 0, NONE);
        step("illegal", NONE, 4'd10, S_FAULT | FLT);
        do_reset();

        // MEM timeout counted from MEM entry, not from the FETCH waits
        fetch(4'd6, 5, NONE);
        step("exec_st2", NONE, 4'd6, S_EXEC);
        for (int i = 0; i < 15; i++) step("mem_tmo_wait", NONE, 4'd6, S_MEM | REQ | ASEL | WE);
        step("mem_tmo", NONE, 4'd6, S_FAULT | FLT);
        do_reset();
        step("after_reset", NONE, 4'd0, S_FETCH | REQ);

        $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
        $finish;
    end

endmodule
